// File: rtl/decoder_pkg.sv
// decoder_pkg: code widths, output-stage states and the one-hot helper shared by the decoder slice.
package decoder_pkg;
    localparam int CODE_W = 3;
    localparam int ONEHOT_W = 8;
    typedef enum logic {IDLE, HOLD} state_e;
    function automatic logic [ONEHOT_W-1:0] onehot(input logic [CODE_W-1:0] code);
        return ONEHOT_W'(1) << code;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular buffer with occupancy count; push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] level_q;
    logic wr_en, rd_en;
    assign full_o  = level_q == (AW+1)'(DEPTH);
    assign empty_o = level_q == '0;
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    assign level_o = level_q;
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din_i;
    end
    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
            level_q <= level_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end
endmodule

// File: rtl/decoder_3to8_buf.sv
// decoder_3to8_buf: buffered 3-to-8 one-hot decoder with valid/ready handshakes and a transfer counter.
module decoder_3to8_buf
    import decoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CODE_W-1:0]       a,
    input  logic                    a_valid,
    output logic                    a_ready,
    output logic [ONEHOT_W-1:0]     y,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        count
);
    state_e state_q, state_d;
    logic [ONEHOT_W-1:0] y_q, y_d;
    logic [CNT_W-1:0] count_q;
    logic [CODE_W-1:0] head;
    logic full, empty, pop;
    sync_fifo #(.WIDTH(CODE_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(a_valid && a_ready),
        .din_i(a),
        .pop_i(pop),
        .dout_o(head),
        .full_o(full),
        .empty_o(empty),
        .level_o(level)
    );
    assign a_ready = !rst && !full;
    assign y = y_q;
    assign y_valid = state_q == HOLD;
    assign count = count_q;
    // The stage reloads whenever it is free or being drained and a code is waiting
    always_comb begin
        pop = !empty && (state_q == IDLE || y_ready);
        state_d = (pop || (state_q == HOLD && !y_ready)) ? HOLD : IDLE;
        y_d = pop ? onehot(head) : (state_d == HOLD ? y_q : '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            y_q <= y_d;
            if (y_valid && y_ready) count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_decoder_3to8_buf.sv
// tb_decoder_3to8_buf: directed and random stimulus checked against a queue-based transaction model.
module tb_decoder_3to8_buf;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    logic clk = 0, rst = 1, a_valid = 0, y_ready = 0;
    logic [2:0] a = '0;
    logic a_ready, y_valid;
    logic [7:0] y;
    logic [2:0] level;
    logic [7:0] count;
    int total = 0, bad = 0;
    int q[$];
    int held = -1;
    int cnt = 0;
    bit acc;

    always #5 clk = ~clk;

    decoder_3to8_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(a_ready),
        .y(y), .y_valid(y_valid), .y_ready(y_ready), .level(level), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, compare against the model's registered view, then advance the model
    task automatic cyc(input bit av, input int code, input bit yr, input bit r);
        rst = r; a_valid = av; a = code[2:0]; y_ready = yr;
        #1;
        chk("a_ready", a_ready, 32'(!r && q.size() != DEPTH));
        chk("y_valid", y_valid, 32'(held >= 0));
        chk("y", y, held >= 0 ? 32'(1) << held : 32'(0));
        chk("level", level, 32'(q.size()));
        chk("count", count, 32'(cnt));
        @(posedge clk);
        acc = 0;
        if (r) begin
            q.delete(); held = -1; cnt = 0;
        end else begin
            acc = av && q.size() != DEPTH;
            if (held >= 0 && yr) cnt = (cnt + 1) % (1 << CNT_W);
            if (q.size() > 0 && (held < 0 || yr)) held = q.pop_front();
            else if (yr) held = -1;
            if (acc) q.push_back(code & 7);
        end
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cyc(0, 0, 0, 1);
        cyc(1, 5, 1, 0);
        cyc(0, 0, 1, 0);
        chk("r031_y", y, 32'h20);
        chk("r031_vld", y_valid, 1);
        cyc(0, 0, 1, 0);
        chk("r031_cnt", count, 1);
        chk("r031_idle", y_valid, 0);
        for (int i = 0; i < 8; i++) cyc(1, i, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        chk("r032_cnt", count, 9);
        for (int k = 0; k < 5; k++) cyc(1, k, 0, 0);
        chk("r033_full", level, 4);
        chk("r033_rdy", a_ready, 0);
        repeat (2) cyc(1, 5, 0, 0);
        cyc(1, 5, 1, 0);
        chk("r034_level", level, 3);
        chk("r034_rdy", a_ready, 1);
        cyc(1, 5, 1, 0);
        cyc(1, 6, 1, 0);
        repeat (8) cyc(0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) cyc(1, k, 0, 0);
        chk("r035_pre", level, 3);
        cyc(0, 0, 1, 1);
        chk("r035_level", level, 0);
        chk("r035_y", y, 0);
        chk("r035_cnt", count, 0);
        repeat (4) cyc(0, 0, 1, 0);
        for (int i = 0; i < 256; i++) cyc(1, int'($urandom_range(7)), 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        chk("r036_wrap", count, 0);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(3) != 0, int'($urandom_range(7)), $urandom_range(3) != 0, $urandom_range(63) == 0);
        repeat (8) cyc(0, 0, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
